dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Shares port A of the core's dual-port RAM among NUM_REQ requesters, e.g. CPU, OAM/HDMA DMA engine and a debug/save-state port.
- Round-robin arbitration, with an optional bounded burst lock for DMA-style copies.
- Forwards the winning access to the RAM in the same cycle and returns read data tagged to the owning requester one cycle later.
- Port B of the RAM (video fetch) is not touched by this block.

Parameters:
- ADDR_W, 13, RAM address width.
- DATA_W, 8, RAM data width.
- NUM_REQ, 3, number of requesters (2..8).
- BURST_MAX, 16, maximum cycles a lock may be held (1..255).

Ports:
- clk_sys  in  1  core clock, shared with the RAM's port-A clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  core clock enable; no access is issued while low.
- req  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  request to hold the grant (burst).
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- gnt  out  NUM_REQ  one-hot; access accepted this cycle.
- rvalid  out  NUM_REQ  one-hot; rdata belongs to this requester.
- rdata  out  DATA_W  read data, passed directly from ram_q.
- ram_ce  out  1  to RAM ce_a.
- ram_addr  out  ADDR_W  to RAM address_a.
- ram_data  out  DATA_W  to RAM data_a.
- ram_wren  out  1  to RAM wren_a.
- ram_q  in  DATA_W  from RAM q_a.

Behaviour:
- Reset is asynchronous: state=ARB, rr_ptr=NUM_REQ-1, lock_cnt=0, lock_owner=0, rvalid=0, rd_pend=0.
- Combinational outputs (gnt, ram_*) are 0 while reset is asserted.
- gnt is combinational and is only asserted when ce=1. At most one bit is set.
- ram_ce = |gnt. ram_addr, ram_data and ram_wren are muxed from the granted requester; they are 0 when there is no grant.
- Handshake: a requester holds req, req_we, req_addr and req_wdata stable until it sees gnt high. The access completes on that clk_sys edge. To issue back-to-back accesses, the requester keeps req high with new fields after the edge.
- Read latency is 1 cycle. On a granted read, rd_pend[i] is registered. rvalid = rd_pend and rdata = ram_q in the following cycle.
- rvalid holds until the next clk_sys edge where ce=1. rd_pend clears when ce=1 and there is no new read grant.
- The RAM port-A output register only loads on non-write ce cycles, so rdata is meaningful only while rvalid is high.
- Writes produce no rvalid.
- ARB state:
  - Winner = first requester with req=1, searching from rr_ptr+1 upward with wrap modulo NUM_REQ.
  - On a grant, rr_ptr <= winner.
  - If the winner also has req_lock=1: move to LOCKED, lock_owner <= winner, lock_cnt <= 1.
- LOCKED state:
  - Only lock_owner can be granted; req from others is ignored.
  - lock_cnt increments on every ce=1 cycle, whether or not a beat is granted.
  - Exit to ARB when the owner drops req_lock, or when lock_cnt == BURST_MAX.
  - The exit is registered; arbitration resumes the next cycle, and rr_ptr stays at the owner.
  - A locked owner that deasserts req but keeps req_lock gets idle cycles, bounded by BURST_MAX.
- ce=0: no grant, no state or counter change, rvalid and rd_pend hold.
- Requester i raising and dropping req without a grant is legal; nothing is recorded.
- Simultaneous events:
  - The lock exit condition and a new beat in the same cycle: the beat is granted, then the exit takes effect.
  - A read grant while a prior rd_pend is outstanding: rd_pend is overwritten with the new one-hot (pipelined reads are allowed, one per cycle).
- Reset mid-burst aborts the lock and discards pending rvalid.

Optional Feature:
- DPRAM_ARB_FIXED_PRIO_EN defined:
  - Requester 0 (CPU) wins any ARB cycle in which it requests.
  - While another requester is LOCKED, a CPU req forces a lock exit at the end of the current cycle, so the CPU waits at most 1 cycle plus the exit cycle.
  - Round-robin still applies among requesters 1..NUM_REQ-1.
- Undefined: pure round-robin as above.

Decomposition:
- Package dpram_arb_pkg:
  - State enum {ARB, LOCKED}.
  - Localparam PTR_W = $clog2(NUM_REQ).
  - Localparam CNT_W = 8.
  - Function rr_pick(req, ptr) returning a one-hot result.
- One sub-module: rr_select. It is the combinational rotate / priority-encode / unrotate used in ARB, and is reusable by other arbiters in the core.

Test Plan:
- Reset then req=3'b111 (all reads, addrs 0x10/0x20/0x30), ce=1 → gnt 001,010,100,001 on successive cycles; rvalid follows each by 1 cycle with the RAM contents of those addrs.
- Req1 write 0xA5 to 0x0100, then req2 read 0x0100 → read granted the cycle after the write; rvalid=100, rdata=0xA5.
- BURST_MAX=4, req1 with req_lock and req held, req0 also requesting → gnt=010 for 4 cycles, then ARB; req0 granted on the next cycle.
- ce toggling 1,0,1 with req=001 → exactly one gnt per ce=1 cycle, none while ce=0; rvalid holds through the ce=0 cycle.
- Assert reset during LOCKED with rd_pend set → gnt=0, rvalid=0 immediately; after release, arbitration starts at requester 0.
- DPRAM_ARB_FIXED_PRIO_EN: req2 locked, req0 asserted → lock exits, req0 granted within 2 cycles; without the macro, req0 waits until BURST_MAX.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the DPRAM
// port-A arbiter and any other small arbiter in the core.
package dpram_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Pointer width is sized for the largest supported requester count (8),
    // so one encoding serves every NUM_REQ in 2..8.
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = $clog2(MAX_REQ);
    localparam int CNT_W   = 8;

    // One-hot pick of the first set bit of req, searching upward from ptr+1
    // and wrapping modulo n. Bits at or above n must be zero.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [PTR_W-1:0]   idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = PTR_W'((int'(ptr) + k) % n);
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: rotate past the last winner,
// priority-encode, and return a one-hot grant in requester order.
module rr_select
    import dpram_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [MAX_REQ-1:0] req_pad;

    // Pad to the helper's fixed width and truncate the pick back to N.
    always_comb begin
        req_pad = MAX_REQ'(req);
        gnt     = N'(rr_pick(req_pad, ptr, N));
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Port-A arbiter for the core's dual-port RAM. Round-robin among NUM_REQ
// requesters with an optional bounded burst lock; the grant goes to the RAM
// combinationally and read data comes back tagged one cycle later.
// Build option: DPRAM_ARB_FIXED_PRIO_EN gives requester 0 (CPU) absolute
// priority in arbitration and lets it cut short another requester's lock.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ARB    | round-robin arbitration from rr_ptr+1
// LOCKED | only lock_owner may be granted; lock_cnt bounds the hold time
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int NUM_REQ   = 3,
    parameter int BURST_MAX = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ce,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_ce,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      ram_wren,
    input  logic [DATA_W-1:0]         ram_q
);

    arb_state_t          state, state_nxt;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]    lock_owner, lock_owner_nxt;
    logic [CNT_W-1:0]    lock_cnt, lock_cnt_nxt;
    logic [NUM_REQ-1:0]  rd_pend, rd_pend_nxt;

    logic [NUM_REQ-1:0]  rr_req;
    logic [NUM_REQ-1:0]  rr_gnt;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic [PTR_W-1:0]    win_idx;
    logic                active;
    logic                win_lock;
    logic                owner_lock;
    logic                cnt_at_max;
    logic                cpu_preempt;

`ifdef DPRAM_ARB_FIXED_PRIO_EN
    // CPU is handled outside the rotation; the others rotate among themselves.
    assign rr_req = {req[NUM_REQ-1:1], 1'b0};
`else
    assign rr_req = req;
`endif

    rr_select #(
        .N(NUM_REQ)
    ) u_rr_select (
        .req(rr_req),
        .ptr(rr_ptr),
        .gnt(rr_gnt)
    );

    // Grant decode and RAM port mux; everything is zero without a grant.
    always_comb begin
        gnt          = '0;
        win_idx      = '0;
        ram_addr     = '0;
        ram_data     = '0;
        ram_wren     = 1'b0;
        active       = ce && !reset;
        owner_onehot = NUM_REQ'(1) << lock_owner;
        cpu_preempt  = 1'b0;
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        cpu_preempt  = req[0] && (lock_owner != '0);
`endif
        if (active) begin
            if (state == ARB) begin
`ifdef DPRAM_ARB_FIXED_PRIO_EN
                gnt = req[0] ? NUM_REQ'(1) : rr_gnt;
`else
                gnt = rr_gnt;
`endif
            end else begin
                gnt = req & owner_onehot;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx  = PTR_W'(i);
                ram_addr = req_addr[i*ADDR_W +: ADDR_W];
                ram_data = req_wdata[i*DATA_W +: DATA_W];
                ram_wren = req_we[i];
            end
        end
        ram_ce     = |gnt;
        win_lock   = |(gnt & req_lock);
        owner_lock = |(req_lock & owner_onehot);
        // lock_cnt counts cycles already held, including the taking grant.
        cnt_at_max = (9'(lock_cnt) + 9'd1) >= 9'(BURST_MAX);
    end

    // Next-state logic; nothing moves on a ce=0 cycle.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        lock_owner_nxt = lock_owner;
        lock_cnt_nxt   = lock_cnt;
        rd_pend_nxt    = rd_pend;
        if (active) begin
            rd_pend_nxt = gnt & ~req_we;
            if (state == ARB) begin
                if (|gnt) begin
                    rr_ptr_nxt = win_idx;
                    if (win_lock && (BURST_MAX > 1)) begin
                        state_nxt      = LOCKED;
                        lock_owner_nxt = win_idx;
                        lock_cnt_nxt   = CNT_W'(1);
                    end
                end
            end else begin
                lock_cnt_nxt = lock_cnt + 1'b1;
                if (!owner_lock || cnt_at_max || cpu_preempt) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end
            end
        end
    end

    // State registers with asynchronous reset; reset drops any lock and
    // any pending read tag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            rr_ptr     <= PTR_W'(NUM_REQ - 1);
            lock_owner <= '0;
            lock_cnt   <= '0;
            rd_pend    <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock_owner <= lock_owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
            rd_pend    <= rd_pend_nxt;
        end
    end

    assign rvalid = rd_pend;
    assign rdata  = ram_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural RAM, behavioural arbitration
// model checked every cycle, directed scenarios with literal expectations,
// then randomized requester traffic. Honours DPRAM_ARB_FIXED_PRIO_EN.
module tb_dpram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int BM = 4;

    logic           clk_sys   = 1'b0;
    logic           reset     = 1'b1;
    logic           ce        = 1'b0;
    logic [N-1:0]   req       = '0;
    logic [N-1:0]   req_we    = '0;
    logic [N-1:0]   req_lock  = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rvalid;
    logic [DW-1:0]  rdata;
    logic           ram_ce;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_data;
    logic           ram_wren;
    logic [DW-1:0]  ram_q = '0;

    int n_checks = 0;
    int n_fail   = 0;

    dpram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(N), .BURST_MAX(BM)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce),
        .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_ce(ram_ce), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM port A: write on wren, output register loads only on read cycles.
    logic [DW-1:0] ram_mem   [0:(1<<AW)-1];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            ram_mem[a]   = DW'(a) ^ 8'h5A;
            model_mem[a] = DW'(a) ^ 8'h5A;
        end
    end

    always @(posedge clk_sys) begin
        if (ram_ce) begin
            if (ram_wren) ram_mem[ram_addr] = ram_data;
            else          ram_q <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state: who was served last, whether a burst is
    // held, by whom and for how many cycles, and the outstanding read.
    int            m_ptr    = N - 1;
    bit            m_locked = 1'b0;
    int            m_owner  = 0;
    int            m_held   = 0;
    int            m_pend   = -1;
    logic [DW-1:0] m_pend_data = '0;
    logic [N-1:0]  exp_gnt_now = '0;

    function automatic int model_winner();
        if (reset || !ce) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        if (req[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
`ifdef DPRAM_ARB_FIXED_PRIO_EN
            if (idx == 0) continue;
`endif
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk_sys) begin : cmp
        int            w;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            cut;
        if (reset) begin
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_rvalid", 32'(rvalid), 32'd0);
            check("rst_ram_ce", 32'(ram_ce), 32'd0);
            m_ptr = N - 1; m_locked = 1'b0; m_owner = 0; m_held = 0; m_pend = -1;
            exp_gnt_now = '0;
        end else begin
            w  = model_winner();
            eg = (w >= 0) ? (N'(1) << w) : '0;
            ea = (w >= 0) ? req_addr[w*AW +: AW] : '0;
            ed = (w >= 0) ? req_wdata[w*DW +: DW] : '0;
            check("gnt", 32'(gnt), 32'(eg));
            check("ram_ce", 32'(ram_ce), 32'(w >= 0));
            check("ram_addr", 32'(ram_addr), 32'(ea));
            check("ram_data", 32'(ram_data), 32'(ed));
            check("ram_wren", 32'(ram_wren), 32'((w >= 0) && req_we[w]));
            check("rvalid", 32'(rvalid), (m_pend >= 0) ? (32'd1 << m_pend) : 32'd0);
            if (m_pend >= 0) check("rdata", 32'(rdata), 32'(m_pend_data));
            exp_gnt_now = eg;
            if (ce) begin
                if (w >= 0 && req_we[w]) model_mem[ea] = ed;
                if (w >= 0 && !req_we[w]) begin
                    m_pend      = w;
                    m_pend_data = model_mem[ea];
                end else begin
                    m_pend = -1;
                end
                if (m_locked) begin
                    m_held++;
                    cut = 1'b0;
`ifdef DPRAM_ARB_FIXED_PRIO_EN
                    cut = (m_owner != 0) && req[0];
`endif
                    if (!req_lock[m_owner] || m_held >= BM || cut) m_locked = 1'b0;
                end else if (w >= 0) begin
                    m_ptr = w;
                    if (req_lock[w] && BM > 1) begin
                        m_locked = 1'b1; m_owner = w; m_held = 1;
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_sys);
    endtask

    task automatic set_rq(input int i, input bit r, input bit we, input bit lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]                 = r;
        req_we[i]              = we;
        req_lock[i]            = lk;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        req = '0; req_we = '0; req_lock = '0;
    endtask

    initial begin
        repeat (3) nxt();
        smp();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);

        // Round-robin over three readers starting at requester 0.
        nxt();
        reset = 1'b0; ce = 1'b1;
        set_rq(0, 1, 0, 0, 13'h010, 8'h00);
        set_rq(1, 1, 0, 0, 13'h020, 8'h00);
        set_rq(2, 1, 0, 0, 13'h030, 8'h00);
        smp(); check("rr_g0", 32'(gnt), 32'b001);
        nxt(); smp(); check("rr_g1", 32'(gnt), 32'b010);
        check("rr_rv0", 32'(rvalid), 32'b001); check("rr_rd0", 32'(rdata), 32'h4A);
        nxt(); smp(); check("rr_g2", 32'(gnt), 32'b100);
        check("rr_rv1", 32'(rvalid), 32'b010); check("rr_rd1", 32'(rdata), 32'h7A);
        nxt(); smp(); check("rr_g3", 32'(gnt), 32'b001);
        check("rr_rv2", 32'(rvalid), 32'b100); check("rr_rd2", 32'(rdata), 32'h6A);
        nxt(); clear_all();
        smp(); check("rr_rv3", 32'(rvalid), 32'b001); check("rr_rd3", 32'(rdata), 32'h4A);

        // Write then read-back through a different requester.
        nxt(); set_rq(1, 1, 1, 0, 13'h0100, 8'hA5);
        smp(); check("wr_gnt", 32'(gnt), 32'b010); check("wr_wren", 32'(ram_wren), 32'd1);
        nxt(); clear_all(); set_rq(2, 1, 0, 0, 13'h0100, 8'h00);
        smp(); check("rd_gnt", 32'(gnt), 32'b100); check("wr_no_rv", 32'(rvalid), 32'd0);
        nxt(); clear_all();
        smp(); check("rd_rv", 32'(rvalid), 32'b100); check("rd_data", 32'(rdata), 32'hA5);

        // Burst lock bounded at BM cycles, then requester 0 gets its turn.
        nxt(); set_rq(0, 1, 0, 0, 13'h010, 8'h00);
        smp(); check("pre_lock", 32'(gnt), 32'b001);
        nxt(); set_rq(1, 1, 0, 1, 13'h020, 8'h00);
        for (int c = 0; c < BM; c++) begin
            smp(); check("burst_gnt", 32'(gnt), 32'b010);
            nxt();
        end
        smp(); check("burst_after", 32'(gnt), 32'b001);

        // Clock-enable gating.
        nxt(); clear_all();
        nxt(); set_rq(0, 1, 0, 0, 13'h010, 8'h00);
        smp(); check("ce_g1", 32'(gnt), 32'b001);
        nxt(); ce = 1'b0;
        smp(); check("ce_g0", 32'(gnt), 32'd0);
        check("ce_hold_rv", 32'(rvalid), 32'b001); check("ce_hold_rd", 32'(rdata), 32'h4A);
        nxt(); ce = 1'b1;
        smp(); check("ce_g2", 32'(gnt), 32'b001); check("ce_rv2", 32'(rvalid), 32'b001);
        nxt(); clear_all();

        // Reset in the middle of a locked burst with a read outstanding.
        nxt(); set_rq(1, 1, 0, 1, 13'h020, 8'h00);
        smp(); check("rl_g0", 32'(gnt), 32'b010);
        nxt(); smp(); check("rl_g1", 32'(gnt), 32'b010);
        #1 reset = 1'b1;
        #1;
        check("rl_gnt0", 32'(gnt), 32'd0);
        check("rl_rv0", 32'(rvalid), 32'd0);
        nxt(); nxt();
        reset = 1'b0; clear_all();
        set_rq(0, 1, 0, 0, 13'h010, 8'h00);
        set_rq(1, 1, 0, 0, 13'h020, 8'h00);
        set_rq(2, 1, 0, 0, 13'h030, 8'h00);
        smp(); check("rl_restart", 32'(gnt), 32'b001);
        nxt(); clear_all();

        // CPU arriving while requester 2 holds a lock.
        nxt(); set_rq(2, 1, 0, 1, 13'h030, 8'h00);
        smp(); check("cpu_lk0", 32'(gnt), 32'b100);
        nxt(); set_rq(0, 1, 0, 0, 13'h010, 8'h00);
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        smp(); check("cpu_lk1", 32'(gnt), 32'b100);
        nxt();
`else
        for (int c = 1; c < BM; c++) begin
            smp(); check("cpu_lkw", 32'(gnt), 32'b100);
            nxt();
        end
`endif
        smp(); check("cpu_win", 32'(gnt), 32'b001);
        nxt(); clear_all();

        // Randomized traffic obeying the hold-until-grant handshake.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nxt();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            ce = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] || exp_gnt_now[i]) begin
                    set_rq(i, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 3) == 0, AW'($urandom_range(0, 31)),
                           DW'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 15) == 0) req_lock[i] = ~req_lock[i];
            end
        end
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
